score_counter: RTL and testbench

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_counter_pkg.sv | 20 ++
 rtl/score_counter_seg7_decoder.sv | 26 ++
 rtl/score_counter.sv | 77 +++++++
 tb/tb_score_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/score_counter_pkg.sv
// score_counter_pkg: shared game encodings (master FSM states) and
// active-low seven-segment constants, bit order {dp,g,f,e,d,c,b,a}.
package score_counter_pkg;
   typedef enum logic [1:0] {
      MS_IDLE = 2'b00,
      MS_PLAY = 2'b01,
      MS_WIN  = 2'b10
   } master_state_t;
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/score_counter_seg7_decoder.sv
// seg7_decoder: combinational BCD to active-low seven-segment decoder.
//   bcd : 4-bit BCD digit in
//   hex : active-low segments {dp,g,f,e,d,c,b,a}; non-BCD inputs blank
module seg7_decoder
   import score_counter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] hex
);
   always_comb begin
      hex = SEG_BLANK;
      case (bcd)
         4'd0: hex = SEG_0;
         4'd1: hex = SEG_1;
         4'd2: hex = SEG_2;
         4'd3: hex = SEG_3;
         4'd4: hex = SEG_4;
         4'd5: hex = SEG_5;
         4'd6: hex = SEG_6;
         4'd7: hex = SEG_7;
         4'd8: hex = SEG_8;
         4'd9: hex = SEG_9;
         default: hex = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/score_counter.sv
// score_counter: two-digit BCD game score with win detection and a
// multiplexed four-digit seven-segment display driver.
//   CLK, RESET           : clock, asynchronous active-high reset
//   TARGET_REACHED       : level, high while the snake head is on the target
//   MASTER_STATE         : 00 idle (clear), 01 play (count), 10/11 hold
//   WIN                  : registered, high once the score reaches WIN_SCORE
//   SCORE_TENS/UNITS     : BCD score digits
//   SEG_SELECT, HEX_OUT  : registered active-low digit enable and segments
module score_counter
   import score_counter_pkg::*;
#(
   parameter int WIN_SCORE    = 10,
   parameter int REFRESH_BITS = 17
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       TARGET_REACHED,
   input  logic [1:0] MASTER_STATE,
   output logic       WIN,
   output logic [3:0] SCORE_UNITS,
   output logic [3:0] SCORE_TENS,
   output logic [3:0] SEG_SELECT,
   output logic [7:0] HEX_OUT
);
   localparam logic [3:0] WIN_UNITS = 4'(WIN_SCORE % 10);
   localparam logic [3:0] WIN_TENS  = 4'(WIN_SCORE / 10);
   logic                    prev;
   logic [REFRESH_BITS-1:0] refresh;
   logic [1:0]              sel;
   logic                    hit, at_max, at_win;
   logic [3:0]              digit;
   logic [7:0]              digit_hex;
   assign hit    = TARGET_REACHED & ~prev;
   assign at_max = (SCORE_TENS == 4'd9) && (SCORE_UNITS == 4'd9);
   assign at_win = (SCORE_TENS == WIN_TENS) && (SCORE_UNITS == WIN_UNITS);
   assign sel    = refresh[REFRESH_BITS-1 -: 2];
   assign digit  = sel[0] ? SCORE_TENS : SCORE_UNITS;
   seg7_decoder u_dec (
      .bcd(digit),
      .hex(digit_hex)
   );
   // WIN compares the registered score, so it rises one edge after the
   // scoring edge; a hit outside play is simply dropped.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         prev        <= 1'b0;
         WIN         <= 1'b0;
         SCORE_UNITS <= 4'd0;
         SCORE_TENS  <= 4'd0;
      end else begin
         prev <= TARGET_REACHED;
         if (MASTER_STATE == MS_IDLE) begin
            WIN         <= 1'b0;
            SCORE_UNITS <= 4'd0;
            SCORE_TENS  <= 4'd0;
         end else if (MASTER_STATE == MS_PLAY && !WIN) begin
            WIN <= at_win;
            if (hit && !at_max) begin
               SCORE_UNITS <= (SCORE_UNITS == 4'd9) ? 4'd0 : SCORE_UNITS + 4'd1;
               SCORE_TENS  <= (SCORE_UNITS == 4'd9) ? SCORE_TENS + 4'd1 : SCORE_TENS;
            end
         end
      end
   end
   // Digits 2 and 3 exist on the board but are always blanked.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         refresh    <= '0;
         SEG_SELECT <= 4'b1110;
         HEX_OUT    <= SEG_0;
      end else begin
         refresh    <= refresh + 1'b1;
         SEG_SELECT <= ~(4'b0001 << sel);
         HEX_OUT    <= sel[1] ? SEG_BLANK : digit_hex;
      end
   end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed plus randomized stimulus on two score_counter
// instances (WIN_SCORE 10 and 99, 3-bit refresh) checked against an
// integer-score reference model.
module tb_score_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tr  = 1'b0;
   logic [1:0] ms  = 2'b00;
   logic       win   [2];
   logic [3:0] units [2];
   logic [3:0] tens  [2];
   logic [3:0] sel   [2];
   logic [7:0] hex   [2];
   int         passes = 0;
   int         total  = 0;
   int         ws     [2] = '{10, 99};
   logic [7:0] segs   [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   logic [3:0] sel_tab[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   int         m_score[2];
   bit         m_win  [2];
   bit         m_prev;
   int         m_cnt;
   logic [3:0] e_sel;
   logic [7:0] e_hex  [2];

   always #5 clk = ~clk;

   score_counter #(.WIN_SCORE(10), .REFRESH_BITS(3)) u10 (
      .CLK(clk), .RESET(rst), .TARGET_REACHED(tr), .MASTER_STATE(ms),
      .WIN(win[0]), .SCORE_UNITS(units[0]), .SCORE_TENS(tens[0]),
      .SEG_SELECT(sel[0]), .HEX_OUT(hex[0]));
   score_counter #(.WIN_SCORE(99), .REFRESH_BITS(3)) u99 (
      .CLK(clk), .RESET(rst), .TARGET_REACHED(tr), .MASTER_STATE(ms),
      .WIN(win[1]), .SCORE_UNITS(units[1]), .SCORE_TENS(tens[1]),
      .SEG_SELECT(sel[1]), .HEX_OUT(hex[1]));

   function automatic void model_reset();
      m_prev = 1'b0;
      m_cnt  = 0;
      e_sel  = 4'b1110;
      for (int i = 0; i < 2; i++) begin
         m_score[i] = 0;
         m_win[i]   = 1'b0;
         e_hex[i]   = 8'hC0;
      end
   endfunction

   function automatic void model_edge();
      bit hit = tr && !m_prev;
      int d   = m_cnt / 2;
      e_sel = sel_tab[d];
      for (int i = 0; i < 2; i++) begin
         e_hex[i] = (d == 0) ? segs[m_score[i] % 10] :
                    (d == 1) ? segs[m_score[i] / 10] : 8'hFF;
         if (ms == 2'b00) begin
            m_score[i] = 0;
            m_win[i]   = 1'b0;
         end else if (ms == 2'b01 && !m_win[i]) begin
            bit reached = (m_score[i] == ws[i]);
            if (hit && m_score[i] < 99) m_score[i]++;
            m_win[i] = reached;
         end
      end
      m_prev = tr;
      m_cnt  = (m_cnt + 1) % 8;
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk("units", i, units[i], m_score[i] % 10);
         chk("tens",  i, tens[i],  m_score[i] / 10);
         chk("win",   i, win[i],   m_win[i]);
         chk("sel",   i, sel[i],   e_sel);
         chk("hex",   i, hex[i],   e_hex[i]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1 check_all();
   endtask

   task automatic hits(input int n);
      for (int k = 0; k < n; k++) begin
         tr = 1'b1; tick();
         tr = 1'b0; tick();
      end
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      tick();
      rst = 1'b0;
      ms  = 2'b01;
      repeat (4) tick();
      tr = 1'b1;
      repeat (5) tick();
      tr = 1'b0;
      tick();
      hits(10);
      tr = 1'b1; tick();
      tr = 1'b0; tick();
      ms = 2'b10;
      hits(3);
      ms = 2'b00;
      hits(2);
      ms = 2'b01;
      hits(3);
      tr = 1'b1; ms = 2'b10; tick();
      ms = 2'b01; tick();
      tr = 1'b0; tick();
      ms = 2'b00; tick();
      ms = 2'b01;
      hits(100);
      repeat (3) tick();
      ms = 2'b00; tick();
      ms = 2'b01;
      hits(7);
      @(posedge clk);
      model_edge();
      #3 rst = 1'b1;
      #1 model_reset();
      check_all();
      repeat (2) tick();
      rst = 1'b0;
      repeat (9) tick();
      for (int k = 0; k < 300; k++) begin
         int r = $urandom_range(0, 19);
         tr = 1'($urandom_range(0, 1));
         ms = (r < 14) ? 2'b01 : (r < 17) ? 2'b10 : (r < 19) ? 2'b11 : 2'b00;
         tick();
      end
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
